alarm_annunciator: RTL and testbench
====================================

# alarm_annunciator

Consumer end of the alarm-logic output. Takes the combinational alarm request (`Y = A & (B | ~C)`) from the alarm decoder, qualifies it against glitches, and latches it. It then drives the siren and a blinking indicator lamp until an operator acknowledge arrives. It sits between the alarm decoder and the board-level siren/LED pins.

## Interface
- `QUAL_CYCLES`, 4: consecutive high samples of `alarm_i` required to trigger (≥1)
- `BLINK_HALF`, 8: lamp half-period in clock cycles (≥1)
- `SIREN_CYCLES`, 64: maximum siren-on duration in cycles before auto-silence (≥1)
- `clk` in 1: system clock, all state changes on rising edge
- `reset` in 1: synchronous, active-high reset
- `arm_i` in 1: arm switch level; 0 forces disarm
- `alarm_i` in 1: alarm request from alarm decoder, treated as asynchronous to nothing (same clock domain)
- `ack_i` in 1: operator acknowledge, level-sampled
- `siren_o` out 1: siren drive
- `lamp_o` out 1: indicator lamp
- `armed_o` out 1: high in every state except DISARMED
- `event_o` out 1: one-cycle pulse on ALARM entry
- `state_o` out 3: current state encoding (debug)

## Operation
- States and encodings: DISARMED=0, ARMED=1, QUALIFY=2, ALARM=3, SILENT=4, ACKED=5. Codes 6 and 7 are illegal and go to DISARMED next cycle.
- Priority per edge: `reset` > `arm_i`=0 (any state → DISARMED) > transitions below.
- DISARMED: `arm_i`=1 → ARMED.
- ARMED: `alarm_i`=1 → QUALIFY with `qual_cnt`=1. If QUAL_CYCLES=1, go directly → ALARM.
- QUALIFY: `alarm_i`=0 → ARMED. Otherwise increment `qual_cnt`; on the sample where the count reaches QUAL_CYCLES → ALARM.
- ALARM: `ack_i`=1 → ACKED. `siren_cnt` reaching SIREN_CYCLES → SILENT. Ack wins if both occur on the same edge. `alarm_i` dropping does not clear the alarm (latched).
- SILENT: `ack_i`=1 → ACKED. `alarm_i` is ignored.
- ACKED: `alarm_i`=0 → ARMED. `ack_i` is ignored.
- Outputs are Moore, decoded from the registered state and counters:
  - `siren_o` = (state==ALARM)
  - `lamp_o` = blink phase in ALARM/SILENT; 1 in ACKED; 0 otherwise
  - `event_o` = first cycle of ALARM
- Blink counter clears on ALARM entry, so the lamp starts at 1. Lamp toggles every BLINK_HALF cycles. The counter is not cleared on ALARM→SILENT, so the phase is continuous.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.

## Timing
- Reset values: state DISARMED; all counters 0; `siren_o`, `lamp_o`, `armed_o`, `event_o` = 0; `state_o`=0.
- Trigger latency: if `alarm_i` is first sampled high at edge k and stays high, state=ALARM after edge k+QUAL_CYCLES−1. `siren_o` and `event_o` go high in the following cycle.
- Without ack, `siren_o` is high exactly SIREN_CYCLES cycles.
- Ack latency: `ack_i` sampled at edge k → `siren_o` low in the cycle after edge k, and lamp steady 1.
- `arm_i` low mid-alarm clears siren and lamp one cycle after the sampling edge.
- `reset` mid-operation behaves identically to power-on reset.

## Structure
- Shared package `alarm_pkg`: state enum `alarm_state_t` with the encodings above, plus default parameter constants.
- One natural sub-module: `blink_gen` (enable, clear, BLINK_HALF → phase output).
- Everything else lives in a single always block plus output decode.

## Test plan
- Defaults; arm, `alarm_i` high 4 cycles → ALARM after 4th sample, `event_o` one pulse, `siren_o` high, `lamp_o` 1 for 8 cycles then 0 for 8.
- `alarm_i` high 3 cycles then low → returns to ARMED, `siren_o` never asserts, `event_o` never pulses.
- Trigger, no ack → `siren_o` high exactly 64 cycles, then SILENT with lamp still blinking; `ack_i` → ACKED with lamp steady 1; drop `alarm_i` → ARMED.
- `ack_i` on the same edge as siren timeout → ACKED, not SILENT.
- `arm_i` low during ALARM → DISARMED next cycle, all outputs 0. `reset` pulse during QUALIFY → all outputs 0, `state_o`=0.
- QUAL_CYCLES=1: a single high sample in ARMED → ALARM on that edge.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm annunciator.
// State codes are also visible on the debug port.
package alarm_pkg;

   typedef enum logic [2:0] {
      DISARMED = 3'd0,
      ARMED    = 3'd1,
      QUALIFY  = 3'd2,
      ALARM    = 3'd3,
      SILENT   = 3'd4,
      ACKED    = 3'd5
   } alarm_state_t;

   localparam int QUAL_CYCLES_DEF  = 4;
   localparam int BLINK_HALF_DEF   = 8;
   localparam int SIREN_CYCLES_DEF = 64;

   // The lamp follows the blink phase only while an alarm is latched but not acknowledged.
   function automatic logic is_blinking(input alarm_state_t s);
      return (s == ALARM) || (s == SILENT);
   endfunction

endpackage

// File: rtl/alarm_annunciator_blink_gen.sv
// Lamp blink divider: phase starts at 1 when cleared and toggles every BLINK_HALF
// enabled cycles. Clearing takes priority over counting.
module blink_gen #(
   parameter int BLINK_HALF = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic phase
);

   localparam int CW = $clog2(BLINK_HALF + 1);
   localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

   logic [CW-1:0] cnt;

   // Half-period counter and phase flip-flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (clr) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (en) begin
         if (cnt >= LAST) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else begin
         cnt   <= cnt;
         phase <= phase;
      end
   end

endmodule

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: qualifies the decoder's alarm request, latches it and drives
// siren and blinking lamp until acknowledged. Outputs are decoded from registers.
module alarm_annunciator
   import alarm_pkg::*;
#(
   parameter int QUAL_CYCLES  = QUAL_CYCLES_DEF,
   parameter int BLINK_HALF   = BLINK_HALF_DEF,
   parameter int SIREN_CYCLES = SIREN_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       arm_i,
   input  logic       alarm_i,
   input  logic       ack_i,
   output logic       siren_o,
   output logic       lamp_o,
   output logic       armed_o,
   output logic       event_o,
   output logic [2:0] state_o
);

   localparam int QW = $clog2(QUAL_CYCLES + 1);
   localparam int SW = $clog2(SIREN_CYCLES + 1);
   localparam logic [QW-1:0] QMAX = QW'(QUAL_CYCLES);
   localparam logic [SW-1:0] SMAX = SW'(SIREN_CYCLES);

   alarm_state_t  state;
   logic [QW-1:0] qual_cnt;
   logic [SW-1:0] siren_cnt;
   logic          blink_en;
   logic          phase;

   // Main state machine with its qualification and siren-duration counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= DISARMED;
         qual_cnt  <= '0;
         siren_cnt <= '0;
      end else if (!arm_i) begin
         state     <= DISARMED;
         qual_cnt  <= '0;
         siren_cnt <= '0;
      end else begin
         case (state)
            DISARMED: begin
               state     <= ARMED;
               qual_cnt  <= '0;
               siren_cnt <= '0;
            end
            ARMED: begin
               if (alarm_i) begin
                  if (QMAX <= QW'(1)) begin
                     state     <= ALARM;
                     qual_cnt  <= '0;
                     siren_cnt <= '0;
                  end else begin
                     state    <= QUALIFY;
                     qual_cnt <= QW'(1);
                  end
               end else begin
                  state    <= ARMED;
                  qual_cnt <= '0;
               end
            end
            QUALIFY: begin
               if (!alarm_i) begin
                  state    <= ARMED;
                  qual_cnt <= '0;
               end else if (qual_cnt >= QMAX - QW'(1)) begin
                  // This sample completes the qualification window.
                  state     <= ALARM;
                  qual_cnt  <= '0;
                  siren_cnt <= '0;
               end else begin
                  state    <= QUALIFY;
                  qual_cnt <= qual_cnt + QW'(1);
               end
            end
            ALARM: begin
               if (ack_i) begin
                  state <= ACKED;
               end else begin
                  if (siren_cnt < SMAX) begin
                     siren_cnt <= siren_cnt + SW'(1);
                  end else begin
                     siren_cnt <= siren_cnt;
                  end
                  if (siren_cnt >= SMAX - SW'(1)) begin
                     state <= SILENT;
                  end else begin
                     state <= ALARM;
                  end
               end
            end
            SILENT: begin
               if (ack_i) begin
                  state <= ACKED;
               end else begin
                  state <= SILENT;
               end
            end
            ACKED: begin
               if (!alarm_i) begin
                  state <= ARMED;
               end else begin
                  state <= ACKED;
               end
            end
            default: begin
               state     <= DISARMED;
               qual_cnt  <= '0;
               siren_cnt <= '0;
            end
         endcase
      end
   end

   // Holding the divider cleared outside ALARM/SILENT makes every alarm start with the lamp lit.
   assign blink_en = is_blinking(state);

   blink_gen #(
      .BLINK_HALF (BLINK_HALF)
   ) u_blink (
      .clk   (clk),
      .reset (reset),
      .en    (blink_en),
      .clr   (~blink_en),
      .phase (phase)
   );

   assign siren_o = (state == ALARM);
   assign event_o = (state == ALARM) && (siren_cnt == '0);
   assign armed_o = (state != DISARMED);
   assign lamp_o  = (state == ACKED) || (blink_en && phase);
   assign state_o = state;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed bench for alarm_annunciator: a cycle model (streak / alarm-age arithmetic)
// checked every cycle, plus literal expectations at key points.
module tb_alarm_annunciator;

   localparam int Q = 4;
   localparam int H = 8;
   localparam int S = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       arm = 1'b0, alarm = 1'b0, ack = 1'b0;
   logic       siren, lamp, armed, evt;
   logic [2:0] st;
   logic       arm1 = 1'b0, alarm1 = 1'b0, ack1 = 1'b0;
   logic       siren1, lamp1, armed1, evt1;
   logic [2:0] st1;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model: 0 idle,1 armed,2 qualifying,3 sounding,4 silenced,5 acknowledged
   int m_st = 0, m_streak = 0, m_age = 0;

   always #5 clk = ~clk;

   alarm_annunciator #(.QUAL_CYCLES(Q), .BLINK_HALF(H), .SIREN_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .arm_i(arm), .alarm_i(alarm), .ack_i(ack),
      .siren_o(siren), .lamp_o(lamp), .armed_o(armed), .event_o(evt), .state_o(st));

   alarm_annunciator #(.QUAL_CYCLES(1), .BLINK_HALF(H), .SIREN_CYCLES(S)) dut_q1 (
      .clk(clk), .reset(reset), .arm_i(arm1), .alarm_i(alarm1), .ack_i(ack1),
      .siren_o(siren1), .lamp_o(lamp1), .armed_o(armed1), .event_o(evt1), .state_o(st1));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task model_step();
      if (reset) begin
         m_st = 0; m_streak = 0; m_age = 0;
      end else if (!arm) begin
         m_st = 0; m_streak = 0;
      end else begin
         case (m_st)
            0: m_st = 1;
            1, 2: begin
               if (alarm) begin
                  m_streak++;
                  if (m_streak >= Q) begin
                     m_st = 3; m_age = 0; m_streak = 0;
                  end else m_st = 2;
               end else begin
                  m_streak = 0; m_st = 1;
               end
            end
            3: begin
               if (ack) m_st = 5;
               else begin
                  m_age++;
                  if (m_age >= S) m_st = 4;
               end
            end
            4: begin
               m_age++;
               if (ack) m_st = 5;
            end
            5: if (!alarm) m_st = 1;
            default: m_st = 0;
         endcase
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("state",  st,    m_st);
         chk("siren",  siren, m_st == 3);
         chk("event",  evt,   (m_st == 3) && (m_age == 0));
         chk("armed",  armed, m_st != 0);
         chk("lamp",   lamp,  (m_st == 5) ||
                              (((m_st == 3) || (m_st == 4)) && ((m_age / H) % 2 == 0)));
      end
   end

   initial begin
      logic [15:0] pat;
      int sc, ec;
      cyc(2);
      reset = 1'b0;
      chk_en = 1'b1;
      chk("rst_state", st, 3'd0);
      chk("rst_outs", {siren, lamp, armed, evt}, 4'b0000);
      chk("rst_q1", {st1, siren1, lamp1, armed1, evt1}, 7'd0);

      // Qualify 4 samples, then run to siren timeout without ack.
      arm = 1'b1; cyc(1);
      chk("armed_state", st, 3'd1);
      alarm = 1'b1; cyc(3);
      chk("qualify_state", st, 3'd2);
      cyc(1);
      chk("alarm_entry", {st, siren, evt, lamp}, {3'd3, 3'b111});
      pat = 16'h0; sc = 0; ec = 0;
      for (int i = 0; i < 80; i++) begin
         if (i < 16) pat = {pat[14:0], lamp};
         sc += int'(siren);
         ec += int'(evt);
         cyc(1);
      end
      chk("blink_pattern", pat, 16'hFF00);
      chk("siren_cycles", sc, 64);
      chk("event_pulses", ec, 1);
      chk("silent_state", {st, lamp}, {3'd4, 1'b1});
      ack = 1'b1; cyc(1); ack = 1'b0;
      chk("acked", {st, siren, lamp}, {3'd5, 1'b0, 1'b1});
      cyc(3);
      chk("acked_hold", {st, lamp}, {3'd5, 1'b1});
      alarm = 1'b0; cyc(1);
      chk("rearm", st, 3'd1);

      // Short glitch: 3 samples only.
      alarm = 1'b1; cyc(3);
      chk("glitch_qual", st, 3'd2);
      alarm = 1'b0; sc = 0; ec = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         sc += int'(siren);
         ec += int'(evt);
      end
      chk("glitch_siren", sc, 0);
      chk("glitch_event", ec, 0);
      chk("glitch_state", st, 3'd1);

      // Ack on the same edge as the siren timeout.
      alarm = 1'b1; cyc(4);
      chk("t4_alarm", st, 3'd3);
      cyc(63);
      chk("t4_pre_timeout", {st, siren}, {3'd3, 1'b1});
      ack = 1'b1; cyc(1); ack = 1'b0;
      chk("t4_ack_wins", {st, siren}, {3'd5, 1'b0});
      alarm = 1'b0; cyc(1);
      chk("t4_rearm", st, 3'd1);

      // Disarm during ALARM, then reset during QUALIFY.
      alarm = 1'b1; cyc(4);
      chk("t5_alarm", st, 3'd3);
      cyc(5);
      arm = 1'b0; cyc(1);
      chk("disarm", {st, siren, lamp, armed, evt}, 7'd0);
      alarm = 1'b0; arm = 1'b1; cyc(1);
      chk("t5_rearm", st, 3'd1);
      alarm = 1'b1; cyc(2);
      chk("t5_qual", st, 3'd2);
      reset = 1'b1; cyc(1);
      chk("mid_reset", {st, siren, lamp, armed, evt}, 7'd0);
      reset = 1'b0; alarm = 1'b0; cyc(1);
      chk("post_reset_arm", st, 3'd1);

      // Single-sample qualification instance.
      arm1 = 1'b1; cyc(1);
      chk("q1_armed", st1, 3'd1);
      alarm1 = 1'b1; cyc(1);
      chk("q1_alarm", {st1, siren1, evt1, lamp1}, {3'd3, 3'b111});
      alarm1 = 1'b0; cyc(1);
      chk("q1_latched", {st1, siren1, evt1}, {3'd3, 1'b1, 1'b0});

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
